// File: rtl/fib_bcd.sv
// fib_bcd: FIFO-buffered 32-bit binary to 10-digit packed BCD converter (double dabble).
// Build macro FIB_BCD_OVERFLOW_EN adds the sticky ASO_OVERFLOW dropped-word flag.
module fib_bcd #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic        ASI_READY,
  input  logic        ASI_VALID,
  input  logic [31:0] ASI_DATA,
  input  logic        ASI_ERROR,
  input  logic        ASO_READY,
  output logic        ASO_VALID,
  output logic [39:0] ASO_DATA,
  output logic        ASO_ERROR,
  output logic        ASO_OVERFLOW
);

  localparam int          AW      = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;

  logic [32:0]     mem_r [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [AW:0]     count_r;
  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic [32:0]     head_s;

  logic [31:0]     bin_r;
  logic [39:0]     bcd_r;
  logic [4:0]      step_r;
  logic [39:0]     adj_s;
  logic [39:0]     bcd_nxt_s;

  logic            load_s;
  logic            step_s;
  logic            done_s;
  logic            err_load_s;

  logic            aso_valid_r;
  logic [39:0]     aso_data_r;
  logic            aso_error_r;

  // Add 3 to every digit that would reach 10 or more after the next doubling.
  function automatic logic [39:0] dabble_adjust(input logic [39:0] bcd);
    logic [39:0] adj;
    adj = bcd;
    for (int i = 0; i < 10; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end else begin
        adj[4*i +: 4] = bcd[4*i +: 4];
      end
    end
    return adj;
  endfunction

  assign full_s    = (count_r == DEPTH_C);
  assign empty_s   = (count_r == '0);
  assign push_s    = ASI_VALID & ~full_s;
  assign head_s    = mem_r[rd_ptr_r];
  assign ASI_READY = ~full_s;

  assign adj_s     = dabble_adjust(bcd_r);
  assign bcd_nxt_s = {adj_s[38:0], bin_r[31]};

  // FIFO storage, written on accepted pushes only.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {ASI_ERROR, ASI_DATA};
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave occupancy unchanged.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state and datapath strobes.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    step_s      = 1'b0;
    done_s      = 1'b0;
    err_load_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!empty_s) begin
          pop_s = 1'b1;
          if (head_s[32]) begin
            err_load_s  = 1'b1;
            state_nxt_s = ST_OUT;
          end else begin
            load_s      = 1'b1;
            state_nxt_s = ST_SHIFT;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        step_s = 1'b1;
        if (step_r == 5'd31) begin
          done_s      = 1'b1;
          state_nxt_s = ST_OUT;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_OUT: begin
        if (ASO_READY) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Double-dabble shift register and step counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      bin_r  <= '0;
      bcd_r  <= '0;
      step_r <= '0;
    end else if (load_s) begin
      bin_r  <= head_s[31:0];
      bcd_r  <= '0;
      step_r <= '0;
    end else if (step_s) begin
      bin_r  <= {bin_r[30:0], 1'b0};
      bcd_r  <= bcd_nxt_s;
      step_r <= step_r + 5'd1;
    end
  end

  // Output registers; data captured on the final step so it stays stable through OUT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      aso_valid_r <= 1'b0;
      aso_data_r  <= '0;
      aso_error_r <= 1'b0;
    end else begin
      aso_valid_r <= (state_nxt_s == ST_OUT);
      if (done_s) begin
        aso_data_r  <= bcd_nxt_s;
        aso_error_r <= 1'b0;
      end else if (err_load_s) begin
        aso_data_r  <= '0;
        aso_error_r <= 1'b1;
      end
    end
  end

  assign ASO_VALID = aso_valid_r;
  assign ASO_DATA  = aso_data_r;
  assign ASO_ERROR = aso_error_r;

`ifdef FIB_BCD_OVERFLOW_EN
  logic ovf_r;

  // Sticky flag: set by any word presented while the FIFO is full.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ovf_r <= 1'b0;
    end else if (ASI_VALID && full_s) begin
      ovf_r <= 1'b1;
    end
  end

  assign ASO_OVERFLOW = ovf_r;
`else
  assign ASO_OVERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_fib_bcd.sv
// tb_fib_bcd: directed scoreboard bench for fib_bcd (latency, ordering, backpressure, reset).
module tb_fib_bcd;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        ASI_READY;
  logic        ASI_VALID = 1'b0;
  logic [31:0] ASI_DATA = 32'd0;
  logic        ASI_ERROR = 1'b0;
  logic        ASO_READY = 1'b1;
  logic        ASO_VALID;
  logic [39:0] ASO_DATA;
  logic        ASO_ERROR;
  logic        ASO_OVERFLOW;

`ifdef FIB_BCD_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  always #5 CLK = ~CLK;

  fib_bcd #(.FIFO_DEPTH(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .ASI_READY    (ASI_READY),
    .ASI_VALID    (ASI_VALID),
    .ASI_DATA     (ASI_DATA),
    .ASI_ERROR    (ASI_ERROR),
    .ASO_READY    (ASO_READY),
    .ASO_VALID    (ASO_VALID),
    .ASO_DATA     (ASO_DATA),
    .ASO_ERROR    (ASO_ERROR),
    .ASO_OVERFLOW (ASO_OVERFLOW)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_hs = -1;
  bit          tput_en = 1'b0;
  bit          last_acc = 1'b0;
  bit          hold_valid = 1'b0;
  logic [40:0] held_val = 41'd0;
  logic [40:0] exp_q [$];
  logic [31:0] fib [48];

  // Reference conversion by repeated division, independent of double dabble.
  function automatic logic [39:0] to_bcd(input logic [31:0] v);
    logic [39:0]     r;
    longint unsigned x;
    r = 40'd0;
    x = 64'(v);
    for (int i = 0; i < 10; i++) begin
      r[4*i +: 4] = 4'(x % 64'd10);
      x = x / 64'd10;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: monitor/scoreboard at the falling edge, return just after the rising edge.
  task automatic tick();
    logic [40:0] e;
    @(negedge CLK);
    if (ASO_VALID) begin
      if (hold_valid) chk("hold_stable", 64'({ASO_ERROR, ASO_DATA}), 64'(held_val));
      if (ASO_READY) begin
        chk("unexpected_output", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("out_data", 64'(ASO_DATA), 64'(e[39:0]));
          chk("out_error", 64'(ASO_ERROR), 64'(e[40]));
        end
        if (tput_en && last_hs >= 0) chk("throughput", 64'(cyc - last_hs), 64'd34);
        last_hs = cyc;
        hold_valid = 1'b0;
      end else begin
        hold_valid = 1'b1;
        held_val = {ASO_ERROR, ASO_DATA};
      end
    end else begin
      hold_valid = 1'b0;
    end
    last_acc = ASI_VALID && ASI_READY;
    if (last_acc) exp_q.push_back({ASI_ERROR, ASI_ERROR ? 40'd0 : to_bcd(ASI_DATA)});
    @(posedge CLK);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [31:0] d, input logic e);
    ASI_VALID = 1'b1;
    ASI_DATA  = d;
    ASI_ERROR = e;
    tick();
    ASI_VALID = 1'b0;
    ASI_ERROR = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!ASO_VALID && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic drain(input int bound);
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_empty", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int n;
    int i;
    int guard;
    fib[0] = 32'd0;
    fib[1] = 32'd1;
    for (int k = 2; k < 48; k++) fib[k] = fib[k-1] + fib[k-2];

    // Reset state
    #2;
    chk("rst_ready", 64'(ASI_READY), 64'd1);
    chk("rst_valid", 64'(ASO_VALID), 64'd0);
    chk("rst_data", 64'(ASO_DATA), 64'd0);
    chk("rst_error", 64'(ASO_ERROR), 64'd0);
    chk("rst_ovf", 64'(ASO_OVERFLOW), 64'd0);
    @(posedge CLK);
    @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Normal word: 55, first push right after reset release
    ASO_READY = 1'b1;
    push(32'd55, 1'b0);
    chk("acc_55", 64'(last_acc), 64'd1);
    wait_valid(n);
    chk("lat_normal", 64'(n), 64'd33);
    chk("data_55", 64'(ASO_DATA), 64'h0000000055);
    drain(50);

    // Error word: 48 with error flag
    push(32'd48, 1'b1);
    wait_valid(n);
    chk("lat_error", 64'(n), 64'd1);
    chk("err_flag", 64'(ASO_ERROR), 64'd1);
    drain(50);

    // Back-to-back large values
    push(32'd2971215073, 1'b0);
    push(32'hFFFFFFFF, 1'b0);
    chk("acc_b2b", 64'(last_acc), 64'd1);
    drain(200);

    // Backpressure: words 1..6 with ASO_READY low
    ASO_READY = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      ASI_VALID = 1'b1;
      ASI_DATA  = 32'(k);
      if (k == 6) chk("ready_full", 64'(ASI_READY), 64'd0);
      tick();
    end
    ASI_VALID = 1'b0;
    chk("dropped_word", 64'(exp_q.size()), 64'd5);
    chk("overflow", 64'(ASO_OVERFLOW), 64'(EXP_OVF));
    for (int k = 0; k < 60; k++) tick();
    chk("held_valid", 64'(ASO_VALID), 64'd1);
    ASO_READY = 1'b1;
    drain(400);

    // Fibonacci F(0)..F(47), stream with sustained throughput check
    tput_en = 1'b1;
    last_hs = -1;
    i = 0;
    guard = 0;
    while (i < 48 && guard < 5000) begin
      ASI_VALID = 1'b1;
      ASI_DATA  = fib[i];
      tick();
      if (last_acc) i++;
      guard++;
    end
    ASI_VALID = 1'b0;
    chk("fib_all_accepted", 64'(i), 64'd48);
    drain(400);
    tput_en = 1'b0;

    // Reset in the middle of SHIFT with two words queued
    push(32'd1000, 1'b0);
    push(32'd2000, 1'b0);
    push(32'd3000, 1'b0);
    for (int k = 0; k < 9; k++) tick();
    RESET = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(ASO_VALID), 64'd0);
    chk("mid_rst_ready", 64'(ASI_READY), 64'd1);
    chk("mid_rst_ovf", 64'(ASO_OVERFLOW), 64'd0);
    exp_q.delete();
    hold_valid = 1'b0;
    tick();
    tick();
    RESET = 1'b0;

    // First push after release accepted at once
    push(32'd77, 1'b0);
    chk("acc_after_rst", 64'(last_acc), 64'd1);
    wait_valid(n);
    chk("lat_after_rst", 64'(n), 64'd33);
    drain(50);
    for (int k = 0; k < 100; k++) tick();
    chk("idle_after_rst", 64'(ASO_VALID), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fib_bcd.md
FIB_BCD -- requirements
Module: fib_bcd

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, input FIFO entries; SHALL be a power of 2, at least 2.
REQ-002 CLK  input  1  system clock, all state updates on rising edge.
REQ-003 RESET  input  1  reset, asynchronous and active-high.
REQ-004 ASI_READY  output  1  sink ready, high when FIFO not full.
REQ-005 ASI_VALID  input  1  sink data valid, from the Fibonacci stage's ASO_VALID.
REQ-006 ASI_DATA  input  32  unsigned binary value to convert.
REQ-007 ASI_ERROR  input  1  upstream error flag, qualified by ASI_VALID.
REQ-008 ASO_READY  input  1  downstream ready.
REQ-009 ASO_VALID  output  1  source data valid.
REQ-010 ASO_DATA  output  40  10 packed BCD digits; digit 0 (least significant) in [3:0], digit 9 in [39:36].
REQ-011 ASO_ERROR  output  1  error flag, qualified by ASO_VALID.
REQ-012 ASO_OVERFLOW  output  1  sticky flag: input word dropped.

Function
REQ-013 The FIFO SHALL push {ASI_ERROR, ASI_DATA} on a rising edge with ASI_VALID=1 and ASI_READY=1.
REQ-014 ASI_VALID=1 while the FIFO is full SHALL drop the word and leave the FIFO unchanged.
REQ-015 Push and pop on the same edge SHALL both take effect, with occupancy unchanged, including when full or when holding one entry.
REQ-016 The FSM SHALL have states IDLE, SHIFT and OUT.
REQ-017 IDLE with FIFO non-empty SHALL pop the head. If its error bit is 0: load the 32-bit shift register, clear the BCD register and step counter, go to SHIFT. If its error bit is 1: go directly to OUT with ASO_DATA=0 and ASO_ERROR=1.
REQ-018 Each SHIFT cycle SHALL perform one double-dabble step: add 3 to every BCD digit >=5, then shift {BCD, binary} left by 1.
REQ-019 After exactly 32 steps SHIFT SHALL go to OUT, with ASO_DATA = BCD result and ASO_ERROR=0.
REQ-020 Latency: on an idle, empty block, ASO_VALID SHALL rise 33 cycles after the accepting edge for a normal word, and 1 cycle after it for an error word.
REQ-021 In OUT, ASO_VALID=1 and ASO_DATA/ASO_ERROR SHALL hold stable until an edge with ASO_READY=1; the FSM then goes to IDLE and ASO_VALID=0 the next cycle.
REQ-022 Words SHALL be output in acceptance order; none lost while ASI_READY is honoured.
REQ-023 Conversion SHALL be exact for all inputs 0 to 4294967295.
REQ-024 The FIFO SHALL keep accepting during SHIFT and OUT.
REQ-025 Sustained throughput SHALL be one word per 34 cycles, including the IDLE pop cycle and the OUT handshake cycle.

Reset
REQ-026 RESET=1 SHALL immediately force: state IDLE, FIFO empty, ASI_READY=1, ASO_VALID=0, ASO_DATA=0, ASO_ERROR=0, ASO_OVERFLOW=0.
REQ-027 Reset during SHIFT or OUT SHALL abandon the current word and all FIFO contents, with no partial output.
REQ-028 The first push SHALL be accepted on the first rising edge after RESET falls.

Configuration
REQ-029 With macro FIB_BCD_OVERFLOW_EN defined, ASO_OVERFLOW SHALL set on any dropped word (REQ-014) and stay set until reset.
REQ-030 Without FIB_BCD_OVERFLOW_EN, ASO_OVERFLOW SHALL be constant 0 and no overflow logic shall be built; all other behaviour is identical.

Verification
REQ-031 ASI_DATA=55, ASI_ERROR=0, ASO_READY=1 -> ASO_VALID 33 cycles later, ASO_DATA=40'h0000000055, ASO_ERROR=0.
REQ-032 ASI_DATA=2971215073 then ASI_DATA=32'hFFFFFFFF, back-to-back -> ASO_DATA=40'h2971215073 then 40'h4294967295, in order.
REQ-033 ASI_DATA=48, ASI_ERROR=1 -> ASO_VALID 1 cycle after accept, ASO_DATA=0, ASO_ERROR=1.
REQ-034 ASO_READY=0 and 6 consecutive valid words 1..6:
- First word popped into conversion; next 4 fill the FIFO; ASI_READY=0.
- 6th word dropped; ASO_OVERFLOW=1 with the macro, 0 without.
- Release ASO_READY -> outputs 1,2,3,4,5, each held until its handshake.
REQ-035 Assert RESET 10 cycles into SHIFT with 2 words queued -> ASO_VALID=0 immediately, ASI_READY=1, no further output after release.
REQ-036 All values 0..47 pushed as Fibonacci results -> every ASO_DATA matches the decimal value digit for digit.
